// File: rtl/quire_to_posit_4_0.sv
// Quire-to-posit<4,0> converter: 3-stage pipeline (magnitude, code, sign/flags) with a one-entry skid latch.
// Optional macro QUIRE_TO_POSIT_EOW_ONLY_EN: only end-of-window beats produce an output beat.
module quire_to_posit_4_0 #(
    parameter  int LOG_NB_ACCUM = 10,
    localparam int QW           = 9 + LOG_NB_ACCUM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rts_i,
    output logic          rtr_o,
    input  logic          sow_i,
    input  logic          eow_i,
    input  logic [QW-1:0] data_i,
    input  logic          sign_i,
    input  logic          zero_i,
    input  logic          NaR_i,
    input  logic          rtr_i,
    output logic          rts_o,
    output logic          sow_o,
    output logic          eow_o,
    output logic [3:0]    posit_o,
    output logic          NaR_o,
    output logic          zero_o
);

    logic          process_en;
    logic          in_take;

    logic          skid_valid;
    logic [QW-1:0] skid_data;
    logic          skid_sign, skid_zero, skid_nar, skid_sow, skid_eow;

    logic          src_valid, src_keep;
    logic [QW-1:0] src_data;
    logic [QW-1:0] src_mag;
    logic          src_sign, src_zero, src_nar, src_sow, src_eow;

    logic          s1_valid;
    logic [QW-1:0] s1_mag;
    logic          s1_sign, s1_zero, s1_nar, s1_sow, s1_eow;

    logic          s2_valid;
    logic [2:0]    s2_code;
    logic          s2_sign, s2_zero, s2_nar, s2_sow, s2_eow;

    logic [3:0]    s3_posit;

    // Ranges are the round-to-nearest-even decision points between adjacent posit<4,0> values.
    function automatic logic [2:0] mag_to_code(input logic [QW-1:0] m);
        if (m == '0)               return 3'd0;
        else if (m <= QW'(5))      return 3'd1;
        else if (m <= QW'(10))     return 3'd2;
        else if (m <= QW'(13))     return 3'd3;
        else if (m <= QW'(20))     return 3'd4;
        else if (m <= QW'(27))     return 3'd5;
        else if (m <= QW'(48))     return 3'd6;
        else                       return 3'd7;
    endfunction

    assign process_en = rtr_i | ~rts_o;
    assign in_take    = rts_i & rtr_o;

    always_comb begin
        src_valid = skid_valid | in_take;
        src_data  = skid_valid ? skid_data : data_i;
        src_sign  = skid_valid ? skid_sign : sign_i;
        src_zero  = skid_valid ? skid_zero : zero_i;
        src_nar   = skid_valid ? skid_nar  : NaR_i;
        src_sow   = skid_valid ? skid_sow  : sow_i;
        src_eow   = skid_valid ? skid_eow  : eow_i;
        src_mag   = src_data[QW-1] ? (~src_data + QW'(1)) : src_data;
`ifdef QUIRE_TO_POSIT_EOW_ONLY_EN
        src_keep  = src_valid & src_eow;
`else
        src_keep  = src_valid;
`endif
    end

    always_comb begin
        s3_posit = {1'b0, s2_code};
        if (s2_nar)
            s3_posit = 4'b1000;
        else if (s2_zero)
            s3_posit = 4'b0000;
        else if (s2_sign)
            s3_posit = 4'b0000 - {1'b0, s2_code};
    end

    // rtr_o lags process_en by a cycle, so one beat may slip in during a stall; the skid catches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rtr_o      <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sign  <= 1'b0;
            skid_zero  <= 1'b0;
            skid_nar   <= 1'b0;
            skid_sow   <= 1'b0;
            skid_eow   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_mag     <= '0;
            s1_sign    <= 1'b0;
            s1_zero    <= 1'b0;
            s1_nar     <= 1'b0;
            s1_sow     <= 1'b0;
            s1_eow     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_code    <= 3'd0;
            s2_sign    <= 1'b0;
            s2_zero    <= 1'b0;
            s2_nar     <= 1'b0;
            s2_sow     <= 1'b0;
            s2_eow     <= 1'b0;
            rts_o      <= 1'b0;
            posit_o    <= 4'b0000;
            NaR_o      <= 1'b0;
            zero_o     <= 1'b0;
            sow_o      <= 1'b0;
            eow_o      <= 1'b0;
        end else begin
            rtr_o <= process_en;
            if (!process_en && in_take) begin
                skid_valid <= 1'b1;
                skid_data  <= data_i;
                skid_sign  <= sign_i;
                skid_zero  <= zero_i;
                skid_nar   <= NaR_i;
                skid_sow   <= sow_i;
                skid_eow   <= eow_i;
            end
            if (process_en) begin
                skid_valid <= 1'b0;

                s1_valid <= src_keep;
                s1_mag   <= src_mag;
                s1_sign  <= src_sign;
                s1_zero  <= src_zero;
                s1_nar   <= src_nar;
                s1_sow   <= src_sow;
                s1_eow   <= src_eow;

                s2_valid <= s1_valid;
                s2_code  <= mag_to_code(s1_mag);
                s2_sign  <= s1_sign;
                s2_zero  <= s1_zero | (s1_mag == '0);
                s2_nar   <= s1_nar;
                s2_sow   <= s1_sow;
                s2_eow   <= s1_eow;

                rts_o   <= s2_valid;
                posit_o <= s3_posit;
                NaR_o   <= s2_nar;
                zero_o  <= ~s2_nar & (s3_posit == 4'b0000);
                sow_o   <= s2_sow;
                eow_o   <= s2_eow;
            end
        end
    end

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Self-checking bench for quire_to_posit_4_0: nearest-posit reference model, queue scoreboard, random back-pressure.
// Honours QUIRE_TO_POSIT_EOW_ONLY_EN the same way as the design build.
module tb_quire_to_posit_4_0;
    localparam int QW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rts_i = 1'b0;
    logic          rtr_o;
    logic          sow_i = 1'b0;
    logic          eow_i = 1'b0;
    logic [QW-1:0] data_i = '0;
    logic          sign_i = 1'b0;
    logic          zero_i = 1'b0;
    logic          NaR_i = 1'b0;
    logic          rtr_i = 1'b1;
    logic          rts_o;
    logic          sow_o;
    logic          eow_o;
    logic [3:0]    posit_o;
    logic          NaR_o;
    logic          zero_o;

    int   check_count = 0;
    int   pass_count = 0;
    int   out_count = 0;
    bit   random_ready = 0;
    logic [7:0] exp_q[$];

    quire_to_posit_4_0 #(.LOG_NB_ACCUM(10)) dut (
        .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o),
        .sow_i(sow_i), .eow_i(eow_i), .data_i(data_i),
        .sign_i(sign_i), .zero_i(zero_i), .NaR_i(NaR_i),
        .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
        .posit_o(posit_o), .NaR_o(NaR_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    // Nearest posit<4,0> value in sixteenths, ties to the even code, never rounding a nonzero value to zero.
    function automatic logic [3:0] model_posit(input logic [QW-1:0] d, input logic s, input logic z, input logic n);
        longint vals[8];
        longint v, mag, bd, dd;
        int best;
        vals = '{0, 4, 8, 12, 16, 24, 32, 64};
        if (n) return 4'b1000;
        v = d[QW-1] ? longint'(d) - (longint'(1) << QW) : longint'(d);
        mag = (v < 0) ? -v : v;
        if (z || mag == 0) return 4'b0000;
        best = 1;
        bd = (mag > 4) ? mag - 4 : 4 - mag;
        for (int c = 2; c < 8; c++) begin
            dd = (mag > vals[c]) ? mag - vals[c] : vals[c] - mag;
            if (dd < bd || (dd == bd && (c % 2) == 0)) begin
                best = c;
                bd = dd;
            end
        end
        return s ? 4'(16 - best) : 4'(best);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic apply_stimulus(input logic [QW-1:0] d, input logic s, input logic z, input logic n,
                                  input logic so, input logic eo);
        bit acc = 0;
        int tries = 0;
        data_i = d; sign_i = s; zero_i = z; NaR_i = n; sow_i = so; eow_i = eo;
        rts_i = 1'b1;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = rtr_o;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) check_output("accept_timeout", 0, 1);
        rts_i = 1'b0;
    endtask

    task automatic wait_output(input string name);
        int n = 0;
        @(negedge clk);
        while (!rts_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rts_o) check_output({name, "_timeout"}, 0, 1);
    endtask

    task automatic send_and_expect(input string name, input logic [QW-1:0] d, input logic s,
                                   input logic z, input logic n, input logic [3:0] expect_posit);
        apply_stimulus(d, s, z, n, 1'b1, 1'b1);
        wait_output(name);
        check_output(name, {NaR_o, zero_o, posit_o}, {expect_posit == 4'b1000, expect_posit == 4'b0000, expect_posit});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rts_o) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Scoreboard: every cycle with rts_o high must present the oldest outstanding expected beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rts_o) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_rts_o", 1, 0);
                end else begin
                    check_output("stream_beat", {posit_o, NaR_o, zero_o, sow_o, eow_o}, exp_q[0]);
                    if (rtr_i) begin
                        void'(exp_q.pop_front());
                        out_count++;
                    end
                end
            end
            if (rts_i && rtr_o) begin
                logic [3:0] p;
                bit keep = 1;
`ifdef QUIRE_TO_POSIT_EOW_ONLY_EN
                keep = eow_i;
`endif
                p = model_posit(data_i, sign_i, zero_i, NaR_i);
                if (keep) exp_q.push_back({p, p == 4'b1000, p == 4'b0000, sow_i, eow_i});
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (random_ready) rtr_i = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int base;
        logic [QW-1:0] d;

        check_output("model_16", model_posit(19'd16, 1'b0, 1'b0, 1'b0), 4'b0100);
        check_output("model_neg16", model_posit(-19'sd16, 1'b1, 1'b0, 1'b0), 4'b1100);
        check_output("model_6_tie", model_posit(19'd6, 1'b0, 1'b0, 1'b0), 4'b0010);
        check_output("model_20_tie", model_posit(19'd20, 1'b0, 1'b0, 1'b0), 4'b0100);
        check_output("model_1_minpos", model_posit(19'd1, 1'b0, 1'b0, 1'b0), 4'b0001);
        check_output("model_big_sat", model_posit(19'h40000, 1'b0, 1'b0, 1'b0), 4'b0111);

        rts_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_output("reset_state", {rts_o, rtr_o, posit_o}, 6'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rts_i = 1'b0;
        @(negedge clk);
        check_output("rtr_before_edge", rtr_o, 0);
        @(negedge clk);
        check_output("rtr_after_release", rtr_o, 1);
        @(posedge clk);
        #1;

        apply_stimulus(19'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_output("latency_c1", rts_o, 0);
        @(negedge clk);
        check_output("latency_c2", rts_o, 0);
        @(negedge clk);
        check_output("latency_c3", {rts_o, posit_o}, 5'b1_0100);
        @(posedge clk);
        #1;

        send_and_expect("neg16", -19'sd16, 1'b1, 1'b0, 1'b0, 4'b1100);
        send_and_expect("mag3", 19'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
        send_and_expect("mag6", 19'd6, 1'b0, 1'b0, 1'b0, 4'b0010);
        send_and_expect("mag10", 19'd10, 1'b0, 1'b0, 1'b0, 4'b0010);
        send_and_expect("mag14", 19'd14, 1'b0, 1'b0, 1'b0, 4'b0100);
        send_and_expect("mag48", 19'd48, 1'b0, 1'b0, 1'b0, 4'b0110);
        send_and_expect("mag49", 19'd49, 1'b0, 1'b0, 1'b0, 4'b0111);
        send_and_expect("mag2p18", 19'h40000, 1'b0, 1'b0, 1'b0, 4'b0111);
        send_and_expect("nar", 19'd5, 1'b0, 1'b0, 1'b1, 4'b1000);
        send_and_expect("zero", 19'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
        drain("directed");

        base = out_count;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    apply_stimulus(19'(4 * i + 3), i[0], 1'b0, 1'b0, 1'b1, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                rtr_i = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rtr_i = 1'b1;
            end
        join
        drain("stall");
        check_output("stall_out_count", out_count - base, 5);

`ifdef QUIRE_TO_POSIT_EOW_ONLY_EN
        base = out_count;
        apply_stimulus(19'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(19'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(19'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(19'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_output("window");
        check_output("window_result", {posit_o, eow_o}, 5'b0100_1);
        drain("window");
        check_output("window_out_count", out_count - base, 1);
`endif

        apply_stimulus(19'd30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(19'd40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_output("midreset_state", {rts_o, rtr_o, posit_o, NaR_o, zero_o, sow_o, eow_o}, 10'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("midreset_rtr", rtr_o, 1);
        base = out_count;
        repeat (6) @(posedge clk);
        #1;
        check_output("midreset_flushed", out_count - base, 0);

        random_ready = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 0) begin
                d = QW'($urandom_range(0, 70));
                if ($urandom_range(0, 1) == 0) d = -d;
            end else begin
                d = QW'($urandom);
            end
            apply_stimulus(d, d[QW-1], ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        random_ready = 0;
        @(posedge clk);
        #2;
        rtr_i = 1'b1;
        drain("random");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
